gcd_arbiter: RTL and testbench

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/gcd_arbiter.sv | 97 +++++++++
 tb/tb_gcd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter: FSM encoding and index helpers.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // Round-robin pointer advance with wrap for non-power-of-two requester counts.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first asserted request at or after i_ptr, ascending with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic          w_found;
  int            w_s;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_s     = 0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_s = int'(i_ptr) + k;
      if (w_s >= NREQ) w_s = w_s - NREQ;
      w_j = IW'(w_s);
      if (!w_found && i_req[w_j]) begin
        w_found  = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx    = w_j;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbitrated subtractive GCD engine: one operand pair in flight,
// result held until the consumer takes it.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_result,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);

  gcd_state_e    r_state, w_nxt;
  logic [IW-1:0] r_ptr, r_id, w_idx;
  logic [NREQ-1:0] w_gnt;
  logic [W-1:0]  r_x, r_y, r_res;
  logic          r_rsp_valid;
  logic          w_accept, w_term, w_hs;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|w_gnt);
  assign w_term   = (r_x == r_y) || (r_x == '0) || (r_y == '0);
  assign w_hs     = r_rsp_valid && rsp_ready;

  // Grants are suppressed under reset so nothing looks accepted in that cycle.
  assign req_ready  = (r_state == IDLE && !rst) ? w_gnt : '0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_id;
  assign rsp_result = r_res;
  assign busy       = (r_state != IDLE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nxt = RUN;
      RUN:     if (w_term)   w_nxt = DONE;
      DONE:    if (w_hs)     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_x   <= req_a[int'(w_idx)*W +: W];
          r_y   <= req_b[int'(w_idx)*W +: W];
          r_id  <= w_idx;
          r_ptr <= IW'(wrap_inc(int'(w_idx), NREQ));
        end
        RUN: begin
          if (w_term) begin
            r_rsp_valid <= 1'b1;
            // x==0 yields y (covers 0,0); every other terminal case yields x.
            r_res       <= (r_x == '0) ? r_y : r_x;
          end else if (r_x > r_y) begin
            r_x <= r_x - r_y;
          end else begin
            r_y <= r_y - r_x;
          end
        end
        DONE: if (w_hs) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: a negedge monitor models the arbiter and
// pushes expected {id, result, due cycle} at each accept, popping on response.
module tb_gcd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [W-1:0]        rsp_result;
  logic                busy;

  gcd_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [W-1:0] res;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_err = 0;
  int unsigned cyc = 0;
  int          m_ptr = 0;
  bit          m_busy = 0, m_seen = 0;
  logic [IW-1:0] h_id;
  logic [W-1:0]  h_res;
  int          served[NREQ];
  int          got_ids[$];
  int          n_rsp = 0;
  logic [NREQ-1:0] acc_vec = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Subtraction count from Euclid quotients: sum of quotients minus one.
  function automatic int unsigned ref_subs(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s;
    logic [W-1:0] t;
    if (a == 0 || b == 0) return 0;
    s = 0;
    while (b != 0) begin s += int'(a / b); t = a % b; a = b; b = t; end
    return s - 1;
  endfunction

  function automatic int rr(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon
    int   w;
    exp_t e;
    acc_vec = req_valid & req_ready & {NREQ{!rst}};
    if (rst) begin
      chk("rst_ready", req_ready, 0);
      m_ptr  = 0;
      m_busy = 0;
      m_seen = 0;
      sb.delete();
    end else if (!m_busy) begin
      w = rr(req_valid, m_ptr);
      chk("grant", req_ready, (w >= 0) ? (1 << w) : 0);
      chk("idle_busy", busy, 0);
      chk("idle_rsp", rsp_valid, 0);
      if (w >= 0) begin
        e.id  = w;
        e.res = ref_gcd(req_a[w*W +: W], req_b[w*W +: W]);
        e.due = cyc + 2 + ref_subs(req_a[w*W +: W], req_b[w*W +: W]);
        sb.push_back(e);
        m_ptr  = (w + 1) % NREQ;
        m_busy = 1;
        m_seen = 0;
      end
    end else begin
      chk("busy_ready", req_ready, 0);
      chk("busy", busy, 1);
      if (sb.size() == 0) begin
        chk("spurious_rsp", rsp_valid, 0);
      end else if (rsp_valid) begin
        if (!m_seen) begin
          chk("rsp_id", rsp_id, sb[0].id);
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_latency", cyc, sb[0].due);
          h_id = rsp_id; h_res = rsp_result; m_seen = 1;
        end else begin
          chk("hold_id", rsp_id, h_id);
          chk("hold_result", rsp_result, h_res);
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          served[e.id]++;
          got_ids.push_back(e.id);
          n_rsp++;
          m_busy = 0;
        end
      end else if (m_seen) begin
        chk("rsp_dropped", rsp_valid, 1);
      end else if (cyc == sb[0].due) begin
        chk("rsp_late", rsp_valid, 1);
      end
    end
  end

  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    chk($sformatf("accept_%0d", i), req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_a[i*W +: W] = $urandom;
    req_b[i*W +: W] = $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      if (!m_busy) break;
    end
    #1;
    chk("drain", m_busy, 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) served[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    send(0, 48, 18); drain();
    send(2, 0, 35);  drain();
    send(2, 0, 0);   drain();
    send(1, 21, 0);  drain();

    // Consumer stalls in DONE while another requester waits.
    rsp_ready = 1'b0;
    send(1, 7, 7);
    req_a[3*W +: W] = 9; req_b[3*W +: W] = 6; req_valid[3] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("done_reached", rsp_valid, 1);
    repeat (10) @(negedge clk);
    chk("stall_valid", rsp_valid, 1);
    chk("stall_ready", req_ready, 0);
    chk("stall_result", rsp_result, 7);
    @(posedge clk); #1; rsp_ready = 1'b1;
    send(3, 9, 6); drain();

    // All four contend with the pointer freshly reset.
    pulse_rst();
    got_ids.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 12; req_b[i*W +: W] = 8;
    end
    req_valid = '1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (got_ids.size() >= 5) break;
    end
    #1; req_valid = '0;
    drain();
    chk("rr_count", got_ids.size(), 5);
    for (int k = 0; k < 5 && k < got_ids.size(); k++)
      chk($sformatf("rr_order_%0d", k), got_ids[k], k % NREQ);

    // Reset mid-computation: nothing must come out, pointer must return to 0.
    send(1, 1000, 1);
    repeat (5) @(posedge clk);
    #1; chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    req_a[1*W +: W] = 15; req_b[1*W +: W] = 10;
    req_a[3*W +: W] = 14; req_b[3*W +: W] = 21;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("ptr_after_rst", req_ready, 4'b0010);
    @(posedge clk); #1; req_valid = '0;
    drain();

    // Random traffic: multiples of a wide g keep loop counts short but use full width.
    base = n_rsp;
    for (int c = 0; c < 60000 && (n_rsp - base) < 2000; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc_vec[i] || !req_valid[i]) begin
          int unsigned g, m, n;
          g = $urandom_range(1, 32'h0800_0000);
          m = $urandom_range(0, 15);
          n = $urandom_range(0, 15);
          req_a[i*W +: W] = W'(g * m);
          req_b[i*W +: W] = W'(g * n);
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
    end
    #1; req_valid = '0; rsp_ready = 1'b1;
    drain();
    chk("rand_done", (n_rsp - base) >= 2000, 1);
    chk("sb_empty", sb.size(), 0);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("no_starve_%0d", i), served[i] > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
